recursive_doubling_adder: RTL and testbench
===========================================

Name: recursive_doubling_adder

Overview:
- 32-bit binary adder with carry-in and carry-out.
- Carries are computed by a recursive-doubling (Kogge-Stone) parallel prefix over kill/propagate/generate (KPG) states.
- Primary use: the mantissa add/subtract datapath of the floating-point adder. Subtraction is performed by passing the 1's complement of b with cin=1.
- Result is registered: one clock, synchronous active-high reset.

Parameters:
- WIDTH, 32, operand and sum width. Must be a power of 2; prefix depth is log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a, b and cin this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (pre-complemented by the caller when subtracting).
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  registered in_valid.

Behaviour:
- Per-bit state:
  - a_i & b_i → G (generate).
  - ~a_i & ~b_i → K (kill).
  - otherwise → P (propagate).
- Bit position -1 (carry-in slot) is G if cin=1, else K.
- Combine operator for hi ∘ lo: result = lo if hi == P, else hi. It is associative.
- Prefix network:
  - log2(WIDTH)+1 levels over WIDTH+1 positions (-1..WIDTH-1).
  - Level k combines position j with position j-2^k wherever j-2^k ≥ -1; other positions pass through.
  - After the final level, no position may hold P.
- Carry into bit i = 1 iff the final prefix state at position i-1 is G.
- sum_i = a_i ^ b_i ^ carry_i.
- cout = 1 iff the final prefix state at position WIDTH-1 is G.
- State encoding: 2 bits; K=2'b00, G=2'b11, P=2'b01.
- Latency: combinational prefix, then a single output register.
  - Operands presented at edge n appear on sum/cout/out_valid after edge n+1.
  - Full throughput: a new operand every cycle.
- Register updates:
  - sum and cout load on every cycle where in_valid=1.
  - When in_valid=0, sum and cout hold their previous values.
  - out_valid <= in_valid every cycle.
- Reset: when rst=1 at an edge, sum=0, cout=0 and out_valid=0. Reset takes priority over in_valid, and an in-flight result is discarded.
- No handshake back-pressure.
- Boundary conditions:
  - All-ones + 0 with cin=1: the full-length propagate chain must give sum=0, cout=1.
  - Any operands with cin=0 and b=0: sum=a, cout=0.
- Result must equal the low WIDTH bits of the (WIDTH+1)-bit value a+b+cin. cout is bit WIDTH of that value.

Decomposition:
- Shared package: the KPG state typedef (2-bit) with constants K/P/G, and the combine function.
- One natural sub-module: kpg_cell. It has two KPG inputs and one KPG output and is instantiated across the prefix levels by generate loops.
- Top level holds per-bit state generation, the prefix levels, sum XOR and the output register.

Test Plan:
- a=0x12345678, b=0x87654321, cin=0 → one cycle later: sum=0x99999999, cout=0, out_valid=1.
- a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1 (worst-case propagate chain).
- Subtract via complement: a=0x00A00000, b=0xFFAFFFFF (~0x00500000), cin=1 → sum=0x00500000, cout=1 (no borrow).
- a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, cout=1. Then in_valid=0 with new operands → sum and cout hold their previous values, out_valid=0.
- Reset mid-stream:
  - Stimulus: in_valid=1, a=5, b=7 in the same cycle rst=1.
  - Response after that edge: sum=0, cout=0, out_valid=0.
  - The next valid operand a=5, b=7, cin=0 yields sum=12.
- Back-to-back random operands for ≥10k cycles → every output matches a+b+cin from the prior cycle, with cout equal to bit 32.

Source files
------------

// File: rtl/recursive_doubling_adder_pkg.sv
// Shared types for the recursive-doubling adder.
// KPG carry states and the prefix combine operator.
package recursive_doubling_adder_pkg;

  typedef enum logic [1:0] {
    KPG_K = 2'b00,
    KPG_P = 2'b01,
    KPG_G = 2'b11
  } kpg_t;

  // hi o lo: a propagating upper span defers to the lower span.
  function automatic kpg_t kpg_combine(
    input kpg_t hi,
    input kpg_t lo
  );
    return (hi == KPG_P) ? lo : hi;
  endfunction

endpackage

// File: rtl/recursive_doubling_adder_kpg_cell.sv
// One prefix node: merges an upper and a lower KPG span.
// Replicated across every level of the prefix network.
module kpg_cell
  import recursive_doubling_adder_pkg::*;
(
  input  kpg_t hi_i,
  input  kpg_t lo_i,
  output kpg_t out_o
);

  assign out_o = kpg_combine(hi_i, lo_i);

endmodule

// File: rtl/recursive_doubling_adder.sv
// Registered WIDTH-bit adder with a Kogge-Stone KPG carry prefix.
// Row index 0 is the carry-in slot; index i+1 holds bit i.
module recursive_doubling_adder
  import recursive_doubling_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int LVL = $clog2(WIDTH) + 1;

  kpg_t [WIDTH:0] init;
  kpg_t [WIDTH:0] fin;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  // Per-bit KPG classification plus the carry-in slot.
  always_comb begin
    init    = '0;
    init[0] = cin ? KPG_G : KPG_K;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] & b[i])
        init[i+1] = KPG_G;
      else if (~a[i] & ~b[i])
        init[i+1] = KPG_K;
      else
        init[i+1] = KPG_P;
    end
  end

  genvar k, j;
  for (k = 0; k < LVL; k++) begin : g_lvl
    kpg_t [WIDTH:0] src;
    kpg_t [WIDTH:0] row;

    if (k == 0) begin : g_first
      assign src = init;
    end else begin : g_next
      assign src = g_lvl[k-1].row;
    end

    for (j = 0; j <= WIDTH; j++) begin : g_pos
      if (j >= (1 << k)) begin : g_cell
        kpg_cell u_cell (
          .hi_i  (src[j]),
          .lo_i  (src[j-(1<<k)]),
          .out_o (row[j])
        );
      end else begin : g_pass
        assign row[j] = src[j];
      end
    end
  end

  assign fin = g_lvl[LVL-1].row;

  // Carry into bit i is the resolved span ending at bit i-1.
  always_comb begin
    carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = (fin[i] == KPG_G);
    end
  end

  assign sum_d  = a ^ b ^ carry;
  assign cout_d = (fin[WIDTH] == KPG_G);

  // Output register: loads on valid, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_recursive_doubling_adder.sv
// Directed and random checks of the registered prefix adder.
// Expected values are hand-computed or from a 33-bit reference add.
module tb_recursive_doubling_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  recursive_doubling_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [31:0] ta, input logic [31:0] tb,
                      input logic tc);
    rst      = r;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    @(posedge clk);
    #1;
  endtask

  logic [32:0] ref_v;
  logic [31:0] exp_sum;
  logic        exp_cout;
  logic        v;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);

    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_sum", {32'h0, sum}, 64'h0);
    chk("rst_cout", {63'h0, cout}, 64'h0);
    chk("rst_ov", {63'h0, out_valid}, 64'h0);

    step(1'b0, 1'b1, 32'h12345678, 32'h87654321, 1'b0);
    chk("add1_sum", {32'h0, sum}, {32'h0, 32'h99999999});
    chk("add1_cout", {63'h0, cout}, 64'h0);
    chk("add1_ov", {63'h0, out_valid}, 64'h1);

    step(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    chk("chain_sum", {32'h0, sum}, 64'h0);
    chk("chain_cout", {63'h0, cout}, 64'h1);

    step(1'b0, 1'b1, 32'h00A00000, 32'hFFAFFFFF, 1'b1);
    chk("sub_sum", {32'h0, sum}, {32'h0, 32'h00500000});
    chk("sub_cout", {63'h0, cout}, 64'h1);

    step(1'b0, 1'b1, 32'hDEADBEEF, 32'h00000000, 1'b0);
    chk("bz_sum", {32'h0, sum}, {32'h0, 32'hDEADBEEF});
    chk("bz_cout", {63'h0, cout}, 64'h0);

    step(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("ones_sum", {32'h0, sum}, {32'h0, 32'hFFFFFFFF});
    chk("ones_cout", {63'h0, cout}, 64'h1);

    step(1'b0, 1'b0, 32'h00000001, 32'h00000002, 1'b0);
    chk("hold_sum", {32'h0, sum}, {32'h0, 32'hFFFFFFFF});
    chk("hold_cout", {63'h0, cout}, 64'h1);
    chk("hold_ov", {63'h0, out_valid}, 64'h0);

    step(1'b0, 1'b1, 32'h00000010, 32'h00000020, 1'b1);
    chk("pre_sum", {32'h0, sum}, 64'h31);

    step(1'b1, 1'b1, 32'd5, 32'd7, 1'b0);
    chk("mrst_sum", {32'h0, sum}, 64'h0);
    chk("mrst_cout", {63'h0, cout}, 64'h0);
    chk("mrst_ov", {63'h0, out_valid}, 64'h0);

    step(1'b0, 1'b1, 32'd5, 32'd7, 1'b0);
    chk("post_sum", {32'h0, sum}, 64'd12);
    chk("post_ov", {63'h0, out_valid}, 64'h1);

    exp_sum  = 32'd12;
    exp_cout = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 7) != 0);
      step(1'b0, v, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (v) begin
        ref_v    = {1'b0, a} + {1'b0, b} + {32'h0, cin};
        exp_sum  = ref_v[31:0];
        exp_cout = ref_v[32];
      end
      chk("rnd_sum", {32'h0, sum}, {32'h0, exp_sum});
      chk("rnd_cout", {63'h0, cout}, {63'h0, exp_cout});
      chk("rnd_ov", {63'h0, out_valid}, {63'h0, v});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
